// File: rtl/sha1_if.sv
// Request/response bundle between the SHA opcode controller and sha1_core:
// one pre-padded block in, one 160-bit digest out.
interface sha1_if #(
    parameter int C_SHA_CHUNK_SIZE  = 512,
    parameter int C_SHA_DIGEST_SIZE = 160
);
    logic                         start;
    logic                         init;
    logic [C_SHA_CHUNK_SIZE-1:0]  block;
    logic                         busy;
    logic                         valid;
    logic [C_SHA_DIGEST_SIZE-1:0] digest;

    modport master (output start, init, block, input busy, valid, digest);
    modport slave  (input start, init, block, output busy, valid, digest);
endinterface

// File: rtl/sha1_core.sv
// Iterative SHA-1 compression engine, one 512-bit block per start pulse.
// Optional macro SHA1_UNROLL2_EN: two rounds per clock (42-cycle latency).
module sha1_core #(
    parameter int C_SHA_CHUNK_SIZE  = 512,
    parameter int C_SHA_DIGEST_SIZE = 160
) (
    input  logic   clk,
    input  logic   resetn,
    sha1_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    localparam logic [159:0] SHA_IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                       32'h10325476, 32'hC3D2E1F0};

`ifdef SHA1_UNROLL2_EN
    localparam logic [6:0] T_STEP = 7'd2;
    localparam logic [6:0] T_LAST = 7'd78;
`else
    localparam logic [6:0] T_STEP = 7'd1;
    localparam logic [6:0] T_LAST = 7'd79;
`endif

    logic [1:0]                   state_r;
    logic                         busy_r;
    logic                         valid_r;
    logic [C_SHA_DIGEST_SIZE-1:0] digest_r;
    logic [6:0]                   t_r;
    logic [159:0]                 h_r;
    logic [159:0]                 st_r;      // working variables {a,b,c,d,e}
    logic [15:0][31:0]            w_r;       // w_r[i] holds W[t+i]

    logic [15:0][31:0]            w_load_s;
    logic [15:0][31:0]            w_next_s;
    logic [159:0]                 h_start_s;
    logic [159:0]                 h_sum_s;
    logic [159:0]                 round_out_s;
    logic [31:0]                  w_new0_s;
    logic [31:0]                  w_new1_s;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [159:0] sha1_round(input logic [159:0] s,
                                                input logic [31:0]  w,
                                                input logic [6:0]   t);
        logic [31:0] a, b, c, d, e, f, k, temp;
        {a, b, c, d, e} = s;
        if (t < 7'd20) begin
            f = (b & c) | (~b & d);
            k = 32'h5A827999;
        end else if (t < 7'd40) begin
            f = b ^ c ^ d;
            k = 32'h6ED9EBA1;
        end else if (t < 7'd60) begin
            f = (b & c) | (b & d) | (c & d);
            k = 32'h8F1BBCDC;
        end else begin
            f = b ^ c ^ d;
            k = 32'hCA62C1D6;
        end
        temp = {a[26:0], a[31:27]} + f + e + k + w;
        return {temp, a, {b[1:0], b[31:2]}, c, d};
    endfunction

    // Block unpacking, IV selection and final per-word digest sum
    always_comb begin
        w_load_s = '0;
        h_sum_s  = '0;
        for (int i = 0; i < 16; i++) begin
            w_load_s[i] = bus.block[C_SHA_CHUNK_SIZE-1-32*i -: 32];
        end
        for (int j = 0; j < 5; j++) begin
            h_sum_s[32*j +: 32] = h_r[32*j +: 32] + st_r[32*j +: 32];
        end
        if (bus.init) begin
            h_start_s = SHA_IV;
        end else begin
            h_start_s = h_r;
        end
    end

    // Round datapath and message-schedule extension
    always_comb begin
        w_new0_s = rotl1(w_r[13] ^ w_r[8] ^ w_r[2] ^ w_r[0]);
        w_new1_s = rotl1(w_r[14] ^ w_r[9] ^ w_r[3] ^ w_r[1]);
`ifdef SHA1_UNROLL2_EN
        round_out_s = sha1_round(sha1_round(st_r, w_r[0], t_r), w_r[1], t_r + 7'd1);
        w_next_s    = {w_new1_s, w_new0_s, w_r[15:2]};
`else
        round_out_s = sha1_round(st_r, w_r[0], t_r);
        w_next_s    = {w_new0_s, w_r[15:1]};
`endif
    end

    // Control FSM, chaining state and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r  <= S_IDLE;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            digest_r <= '0;
            t_r      <= 7'd0;
            h_r      <= SHA_IV;
            st_r     <= '0;
            w_r      <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        w_r     <= w_load_s;
                        h_r     <= h_start_s;
                        st_r    <= h_start_s;
                        valid_r <= 1'b0;
                        t_r     <= 7'd0;
                        busy_r  <= 1'b1;
                        state_r <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    st_r <= round_out_s;
                    w_r  <= w_next_s;
                    t_r  <= t_r + T_STEP;
                    if (t_r == T_LAST) begin
                        state_r <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    h_r      <= h_sum_s;
                    digest_r <= h_sum_s;
                    valid_r  <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.valid  = valid_r;
    assign bus.digest = digest_r;
endmodule

// File: tb/tb_sha1_core.sv
// Directed-vector bench for sha1_core using FIPS 180 example digests.
// Works for both builds; latency follows SHA1_UNROLL2_EN.
module tb_sha1_core;
`ifdef SHA1_UNROLL2_EN
    localparam int LAT = 41;
`else
    localparam int LAT = 81;
`endif

    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    // 448-bit message: the 0x80 terminator fits in block 1, the length goes in block 2
    localparam logic [511:0] BLK_L1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_L2 = {480'h0, 32'h000001C0};

    localparam logic [159:0] D_EMPTY = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
    localparam logic [159:0] D_ABC   = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] D_LONG  = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    sha1_if bus ();

    sha1_core dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one block, optionally poke an ignored start at cycle intf, and check the result
    task automatic run_block(input string tag, input logic [511:0] blk, input logic ini,
                             input logic [159:0] exp, input int intf);
        int          cycles;
        int          stable_err;
        int          busy_err;
        logic [159:0] prev;
        @(negedge clk);
        prev      = bus.digest;
        bus.start = 1'b1;
        bus.init  = ini;
        bus.block = blk;
        @(negedge clk);
        bus.start  = 1'b0;
        cycles     = 1;
        stable_err = 0;
        busy_err   = 0;
        while (!bus.valid && cycles < 200) begin
            if (bus.digest !== prev) stable_err++;
            if (!bus.busy) busy_err++;
            if (intf != 0 && cycles == intf) begin
                bus.start = 1'b1;
                bus.init  = 1'b1;
                bus.block = BLK_EMPTY;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, 160'(cycles), 160'(LAT + 1));
        chk({tag, "_digest"}, bus.digest, exp);
        chk({tag, "_digest_stable"}, 160'(stable_err), 160'd0);
        chk({tag, "_busy_during"}, 160'(busy_err), 160'd0);
        chk({tag, "_busy_after"}, 160'(bus.busy), 160'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.init  = 1'b0;
        bus.block = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 160'(bus.busy), 160'd0);
        chk("reset_valid", 160'(bus.valid), 160'd0);
        chk("reset_digest", bus.digest, 160'd0);
        resetn = 1'b1;

        run_block("empty", BLK_EMPTY, 1'b1, D_EMPTY, 0);
        run_block("abc", BLK_ABC, 1'b1, D_ABC, 0);
        run_block("long_b1", BLK_L1, 1'b1, 160'hf4286818c37b27ae0408f581846771484a566572, 0);
        run_block("long_b2", BLK_L2, 1'b0, D_LONG, 0);

        // start while busy must be dropped
        run_block("ignored", BLK_ABC, 1'b1, D_ABC, (LAT + 1) / 2);
        repeat (3) @(negedge clk);
        chk("ignored_idle", 160'(bus.busy), 160'd0);
        chk("ignored_hold", bus.digest, D_ABC);

        // reset mid-block, then chain with init=0 to prove H returned to the IV
        @(negedge clk);
        bus.start = 1'b1;
        bus.init  = 1'b1;
        bus.block = BLK_ABC;
        @(negedge clk);
        bus.start = 1'b0;
        repeat ((LAT + 1) * 50 / 82 - 1) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("midreset_busy", 160'(bus.busy), 160'd0);
        chk("midreset_valid", 160'(bus.valid), 160'd0);
        chk("midreset_digest", bus.digest, 160'd0);
        run_block("after_reset", BLK_ABC, 1'b0, D_ABC, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
